// File: rtl/fetch_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the MIPS fetch sequencer.
package fetch_sequencer_pkg;

  localparam logic [5:0]  OpJ            = 6'h02;
  localparam logic [31:0] HaltWord       = 32'h0000_0000;
  localparam logic [31:0] ResetPcDefault = 32'h0040_0000;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StHalt,
    StError
  } state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory req/ack bus plus downstream valid/ready issue port.
interface fetch_sequencer_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    output inst,
    output inst_valid,
    input  inst_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    input  inst,
    input  inst_valid,
    output inst_ready
  );

endinterface

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Sequential PC (+4, wrapping) or J-type target taken from the current instruction.
module fetch_sequencer_next_pc_calc
  import fetch_sequencer_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] pc_plus4;

  always_comb begin
    pc_plus4 = pc_i + 32'd4;
    if (inst_i[31:26] == OpJ) begin
      // Jump region is the 256 MB segment of the delay-slot address.
      next_pc_o = {pc_plus4[31:28], inst_i[25:0], 2'b00};
    end else begin
      next_pc_o = pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: owns the PC, fetches over req/ack, issues over valid/ready.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] ResetPc = ResetPcDefault,
  parameter int unsigned Timeout = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  fetch_sequencer_if.master          bus,
  output logic [31:0]                pc_o,
  output logic                       halted_o,
  output logic                       error_o,
  output logic [31:0]                inst_count_o
);

  localparam logic [7:0] TmoLast = 8'(Timeout - 1);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        inst_valid_q;
  logic        mem_req_q;
  logic        halted_q;
  logic        error_q;
  logic [31:0] inst_count_q;
  logic [7:0]  tmo_q;
  logic [31:0] next_pc;

  fetch_sequencer_next_pc_calc u_next_pc_calc (
    .pc_i      (pc_q),
    .inst_i    (inst_q),
    .next_pc_o (next_pc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      pc_q         <= ResetPc;
      inst_q       <= 32'h0;
      inst_valid_q <= 1'b0;
      mem_req_q    <= 1'b0;
      halted_q     <= 1'b0;
      error_q      <= 1'b0;
      inst_count_q <= 32'h0;
      tmo_q        <= 8'h0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q   <= StFetch;
            mem_req_q <= 1'b1;
            tmo_q     <= 8'h0;
          end
        end
        StFetch: begin
          // An ack takes priority over a timeout expiring on the same edge.
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            tmo_q     <= 8'h0;
            if (bus.mem_rdata == HaltWord) begin
              state_q  <= StHalt;
              halted_q <= 1'b1;
            end else begin
              state_q      <= StIssue;
              inst_q       <= bus.mem_rdata;
              inst_valid_q <= 1'b1;
            end
          end else begin
            tmo_q <= tmo_q + 8'd1;
            if (tmo_q == TmoLast) begin
              state_q   <= StError;
              error_q   <= 1'b1;
              mem_req_q <= 1'b0;
            end
          end
        end
        StIssue: begin
          if (bus.inst_ready) begin
            pc_q         <= next_pc;
            inst_count_q <= sat_inc32(inst_count_q);
            inst_valid_q <= 1'b0;
            mem_req_q    <= 1'b1;
            state_q      <= StFetch;
          end
        end
        default: begin
          // Halt and error are terminal until reset.
          mem_req_q    <= 1'b0;
          inst_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = pc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_valid = inst_valid_q;
  assign pc_o           = pc_q;
  assign halted_o       = halted_q;
  assign error_o        = error_q;
  assign inst_count_o   = inst_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; outputs sampled on the falling edge.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] pc;
  logic        halted;
  logic        error;
  logic [31:0] inst_count;

  int n_checks;
  int n_pass;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .ResetPc (32'h0040_0000),
    .Timeout (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .bus          (bus),
    .pc_o         (pc),
    .halted_o     (halted),
    .error_o      (error),
    .inst_count_o (inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " pc"}, pc, 32'h0040_0000);
    check({tag, " mem_addr"}, bus.mem_addr, 32'h0040_0000);
    check({tag, " mem_req"}, 32'(bus.mem_req), 32'd0);
    check({tag, " inst_valid"}, 32'(bus.inst_valid), 32'd0);
    check({tag, " inst"}, bus.inst, 32'h0);
    check({tag, " halted"}, 32'(halted), 32'd0);
    check({tag, " error"}, 32'(error), 32'd0);
    check({tag, " count"}, inst_count, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Zero-wait fetch from FETCH state, then immediate accept; expects pc to move to exp_next.
  task automatic fetch_issue(input string tag, input logic [31:0] word,
                             input logic [31:0] exp_next);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = word;
    step();
    bus.mem_ack = 1'b0;
    check({tag, " inst"}, bus.inst, word);
    check({tag, " valid"}, 32'(bus.inst_valid), 32'd1);
    check({tag, " req low in issue"}, 32'(bus.mem_req), 32'd0);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    check({tag, " next pc"}, pc, exp_next);
    check({tag, " req back"}, 32'(bus.mem_req), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    rst            = 1'b1;
    start          = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'h0;
    bus.inst_ready = 1'b0;
    step();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Straight-line fetch, then halt.
    do_start();
    check("first req", 32'(bus.mem_req), 32'd1);
    check("first addr", bus.mem_addr, 32'h0040_0000);
    fetch_issue("lin0", 32'h2008_0001, 32'h0040_0004);
    check("lin0 count", inst_count, 32'd1);
    fetch_issue("lin1", 32'h2009_0002, 32'h0040_0008);
    check("lin1 count", inst_count, 32'd2);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0;
    step();
    bus.mem_ack = 1'b0;
    check("halt halted", 32'(halted), 32'd1);
    check("halt valid", 32'(bus.inst_valid), 32'd0);
    check("halt req", 32'(bus.mem_req), 32'd0);
    check("halt pc", pc, 32'h0040_0008);

    // Halt is sticky and ignores start/ack/ready.
    start          = 1'b1;
    bus.mem_ack    = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    bus.inst_ready = 1'b1;
    step();
    step();
    start          = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.inst_ready = 1'b0;
    check("sticky halted", 32'(halted), 32'd1);
    check("sticky req", 32'(bus.mem_req), 32'd0);
    check("sticky valid", 32'(bus.inst_valid), 32'd0);
    check("sticky pc", pc, 32'h0040_0008);
    check("sticky count", inst_count, 32'd2);

    // Jumps.
    do_reset();
    check_reset_outputs("reset2");
    do_start();
    fetch_issue("j0", 32'h2008_0001, 32'h0040_0004);
    fetch_issue("j1", 32'h0810_0000, 32'h0040_0000);
    fetch_issue("jal not j", 32'h0C10_0000, 32'h0040_0004);
    fetch_issue("j far", 32'h0BFF_FFFF, 32'h0FFF_FFFC);
    fetch_issue("j seg", 32'h0810_000C, 32'h1040_0030);
    check("jump count", inst_count, 32'd5);

    // Wait states then backpressure.
    do_reset();
    do_start();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("ws req %0d", i), 32'(bus.mem_req), 32'd1);
      if (i == 5) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h2008_0001;
      end
      step();
    end
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp valid %0d", i), 32'(bus.inst_valid), 32'd1);
      check($sformatf("bp inst %0d", i), bus.inst, 32'h2008_0001);
      check($sformatf("bp pc %0d", i), pc, 32'h0040_0000);
      bus.inst_ready = (i == 3);
      step();
    end
    bus.inst_ready = 1'b0;
    check("bp pc advanced", pc, 32'h0040_0004);
    check("bp valid dropped", 32'(bus.inst_valid), 32'd0);
    check("bp count", inst_count, 32'd1);

    // Ack on the 16th FETCH cycle beats the timeout.
    for (int i = 0; i < 15; i++) step();
    check("pre-tmo error", 32'(error), 32'd0);
    check("pre-tmo req", 32'(bus.mem_req), 32'd1);
    fetch_issue("late ack", 32'h2009_0002, 32'h0040_0008);
    check("late ack error", 32'(error), 32'd0);

    // No ack for 16 cycles -> error.
    for (int i = 0; i < 15; i++) step();
    check("tmo 15 error", 32'(error), 32'd0);
    step();
    check("tmo error", 32'(error), 32'd1);
    check("tmo req", 32'(bus.mem_req), 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h2008_0001;
    step();
    bus.mem_ack = 1'b0;
    check("tmo sticky", 32'(error), 32'd1);
    check("tmo no issue", 32'(bus.inst_valid), 32'd0);

    // Async reset during FETCH with a pending ack.
    do_reset();
    do_start();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    #2 rst = 1'b1;
    #1 check_reset_outputs("async fetch");
    step();
    rst = 1'b0;
    step();
    check("late ack req", 32'(bus.mem_req), 32'd0);
    check("late ack valid", 32'(bus.inst_valid), 32'd0);
    check("late ack inst", bus.inst, 32'h0);
    bus.mem_ack = 1'b0;
    do_start();
    check("restart addr", bus.mem_addr, 32'h0040_0000);
    check("restart req", 32'(bus.mem_req), 32'd1);

    // Async reset during ISSUE.
    fetch_issue("pre-issue", 32'h2008_0001, 32'h0040_0004);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h2009_0002;
    step();
    bus.mem_ack = 1'b0;
    check("issue before rst", 32'(bus.inst_valid), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async issue");
    step();
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle instruction-fetch controller for the MIPS front end.
- Owns the PC and issues word fetches to a variable-latency instruction memory over a req/ack handshake.
- Hands each fetched instruction downstream over a valid/ready handshake.
- Resolves J (opcode 6'h02) targets versus PC+4.
- Stops on the all-zero halt word, or on a memory timeout.

Parameters:
RESET_PC, 32'h00400000, PC value loaded on reset
TIMEOUT, 16, maximum FETCH cycles without mem_ack before entering ERROR (range 1..255)

Ports:
clock  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins fetching when in IDLE
mem_req  output  1  fetch request to instruction memory
mem_addr  output  32  byte address of the fetch; always equals pc
mem_ack  input  1  memory has returned mem_rdata this cycle
mem_rdata  input  32  instruction word, valid when mem_ack=1
inst  output  32  latched instruction presented downstream
inst_valid  output  1  inst is valid
inst_ready  input  1  downstream accepts inst
pc  output  32  address of the instruction currently being fetched or issued
halted  output  1  sticky; halt word fetched
error  output  1  sticky; fetch timeout
inst_count  output  32  number of instructions accepted downstream; saturating

Behaviour:
- Reset (async, any state, mid-transaction included):
  - state=IDLE, pc=RESET_PC, inst=0, inst_valid=0, mem_req=0, halted=0, error=0, inst_count=0, timeout counter=0.
  - An ack arriving after reset is ignored.
- All outputs are registered or decoded from state; mem_addr=pc combinationally.
- States and transitions:
  - IDLE: start=1 -> FETCH. start is ignored in every other state.
  - FETCH: mem_req=1.
    - Sample mem_ack each edge.
    - mem_ack=1 and mem_rdata==0 -> HALT; halted=1, inst_valid stays 0, pc unchanged.
    - mem_ack=1 and mem_rdata!=0 -> ISSUE; inst<=mem_rdata, inst_valid<=1, timeout counter cleared.
    - mem_ack=0 -> timeout counter+1; counter reaching TIMEOUT -> ERROR, error=1.
    - mem_ack=1 on the same edge the counter would reach TIMEOUT: ack wins.
  - ISSUE: inst_valid=1, inst held stable, mem_req=0.
    - inst_ready=1 -> pc<=next_pc, inst_count+1 (saturates at 32'hFFFFFFFF), inst_valid<=0, -> FETCH.
  - HALT, ERROR: terminal until reset. mem_req=0, inst_valid=0.
- next_pc computation:
  - pc_plus4 = pc + 32'd4, wrapping modulo 2^32.
  - inst[31:26]==6'h02: next_pc = {pc_plus4[31:28], inst[25:0], 2'b00}.
  - Otherwise: next_pc = pc_plus4.
  - pc[1:0] is therefore always 2'b00.
- Latency: zero-wait memory with ack in the first FETCH cycle and ready held high gives 2 cycles per instruction (FETCH, ISSUE). The first mem_req is seen one cycle after start.
- mem_ack outside FETCH is ignored.
- inst_ready outside ISSUE is ignored.

Decomposition:
- Shared header mips.h holds:
  - opcode constant OP_J=6'h02
  - HALT_WORD=32'h0
  - RESET_PC default 32'h00400000
  - state encoding constants IDLE/FETCH/ISSUE/HALT/ERROR
- One combinational sub-module, next_pc_calc (inputs pc, inst; output next_pc), holds the +4 and jump-target logic so it can be unit-tested alone.

Test Plan:
- Straight-line fetch: reset, start; memory acks same cycle with 0x20080001, 0x20090002, then 0 -> pcs 00400000, 00400004, 00400008; inst_count=2; halted=1; back-to-back rate of 2 cycles per instruction.
- Jump: at 00400004 return 0x08100000 -> next fetch at 00400000. Return 0x0810000C at pc 0x0FFFFFFC -> pc_plus4=10000000, target 10400030.
- Wait states and backpressure: ack delayed 5 cycles, then inst_ready held low 3 cycles -> mem_req high for 6 cycles; inst stable and inst_valid high 4 cycles; pc advances only on the ready edge.
- Timeout: TIMEOUT=16, never ack -> error=1 after 16 FETCH cycles, mem_req=0. Ack on exactly the 16th cycle -> no error, enters ISSUE.
- Reset mid-operation: assert reset during FETCH with a pending ack and during ISSUE -> all outputs return to reset values asynchronously; a late ack is ignored; start restarts fetch from 00400000.
- Sticky and ignored inputs: in HALT, pulse start and toggle mem_ack/inst_ready -> state unchanged, halted stays 1.
